// File: rtl/calc_pkg.sv
// Shared constants for the calculator operand datapath.
// Selection modes, default geometry and counter width.
package calc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_CH  = 4;

  localparam int CNT_W = 16;

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant: first requester at or above ptr, wrapping.
// Doubled request vector turns the wrap into a linear scan.
module rr_grant #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] idx
);

  localparam int PW = $clog2(2 * N_CH);

  logic [2*N_CH-1:0] dbl;
  logic [PW-1:0]     pos;
  logic [PW-1:0]     hit;
  logic              found;

  assign dbl = {req, req};

  // scan N_CH slots upward from ptr, keep the first set one
  always_comb begin
    found = 1'b0;
    hit   = '0;
    pos   = '0;
    for (int j = 0; j < N_CH; j++) begin
      pos = PW'(ptr) + PW'(j);
      if (!found && dbl[pos]) begin
        found = 1'b1;
        if (pos >= PW'(N_CH))
          hit = pos - PW'(N_CH);
        else
          hit = pos;
      end
    end
    idx = SEL_W'(hit);
    if (found)
      grant = {{(N_CH-1){1'b0}}, 1'b1} << idx;
    else
      grant = '0;
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel operand selector: fixed or round-robin, one-entry out reg.
// MUX_ARB_CNT_EN adds a saturating accepted-transfer counter.
module mux_arb_reg
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
`ifdef MUX_ARB_CNT_EN
  output logic [CNT_W-1:0]      out_count,
`endif
  input  logic                  out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [N_CH-1:0]  rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N_CH-1:0]  fx_gnt;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] g_idx;
  logic [WIDTH-1:0] g_data;
  logic             space;
  logic             accept;

  rr_grant #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_gnt),
    .idx   (rr_idx)
  );

  // out-of-range sel shifts the bit off the top: no grant
  assign fx_gnt = {{(N_CH-1){1'b0}}, 1'b1} << sel;

  assign grant = (mode == MODE_RR) ? rr_gnt : fx_gnt;
  assign g_idx = (mode == MODE_RR) ? rr_idx : sel;

  assign space    = ~out_valid | out_ready;
  assign in_ready = grant & {N_CH{space & en & rst_n}};
  assign accept   = |(in_valid & in_ready);

  // one-hot OR mux of the granted channel's data
  always_comb begin
    g_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i])
        g_data = g_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // output stage: load on accept, clear on drain, hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= g_data;
      out_ch    <= g_idx;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end
  end

  // rr pointer moves past the winner only on a round-robin accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && mode == MODE_RR) begin
      if (rr_idx == SEL_W'(N_CH - 1))
        ptr <= '0;
      else
        ptr <= rr_idx + 1'b1;
    end
  end

`ifdef MUX_ARB_CNT_EN
  // saturating count of accepted transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_count <= '0;
    else if (accept && out_count != '1)
      out_count <= out_count + 1'b1;
  end
`endif

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised N-channel, WIDTH-bit operand selector for the calculator datapath; the successor to the fixed 4:1 8-bit gated mux.
- Adds two selection modes: fixed select and round-robin arbitration among valid channels.
- Adds a per-channel valid/ready handshake and a one-entry registered output stage.
- Sits between operand/keypad sources and the ALU/display path.

Parameters:
- WIDTH, 8, data width per channel.
- N_CH, 4, number of input channels (2..16; need not be a power of 2).
- SEL_W, $clog2(N_CH), select/channel-index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  acceptance enable; low blocks new transfers.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel data valid.
- in_ready  output  N_CH  per-channel accept strobe.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream consumes when high with out_valid.

Behaviour:
- Reset (async, rst_n low): out_data=0, out_ch=0, out_valid=0, RR pointer=0. in_ready=0 while in reset.
- Slot free: space = ~out_valid | out_ready.
- Grant is combinational and one-hot (or zero):
  - Fixed mode: grant[sel] = 1 if sel < N_CH. If sel >= N_CH, no grant.
  - RR mode: grant = first i with in_valid[i] set, searching from ptr upward, wrapping modulo N_CH. Zero if no channel is valid.
- in_ready[i] = grant[i] & space & en.
  - in_ready must not depend on in_valid[i] in fixed mode.
  - In RR mode, in_ready depends on in_valid by construction.
- Accept when in_valid[g] & in_ready[g]:
  - Next edge: out_data = channel g data, out_ch = g, out_valid = 1.
  - Latency is 1 cycle.
- Drain (out_valid & out_ready) with no accept: out_valid=0 and out_data cleared to 0. out_data is 0 whenever out_valid=0, matching the old en-low-gives-zero behaviour.
- Simultaneous drain and accept: new data loads, out_valid stays 1. Sustained throughput is 1 transfer/cycle.
- Stall (out_valid & ~out_ready): out_data and out_ch hold stable; all in_ready=0.
- en=0: no accepts; an already-held output may still drain.
- RR pointer:
  - Updates only on an RR-mode accept: ptr = (g+1) mod N_CH. When g = N_CH-1, ptr wraps to 0.
  - Holds in fixed mode.
- mode/sel changes take effect combinationally on the current cycle's grant. A held output is unaffected.
- Reset asserted mid-transfer: the output register clears immediately and the in-flight datum is dropped.

Optional Feature:
- Macro: MUX_ARB_CNT_EN.
- Defined: adds output out_count [15:0].
  - Counts accepted transfers, saturating at 16'hFFFF.
  - Reset value 0.
  - Increments on the same edge that loads out_data.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package calc_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Default WIDTH=8 and N_CH=4 constants.
  - CNT_W=16.
- One sub-module, rr_grant (combinational):
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: one-hot grant[N_CH] and encoded idx[SEL_W].
  - Implemented as a doubled-vector priority search.
- Handshake, output register and counter stay in mux_arb_reg.

Test Plan:
- Reset, idle: rst_n low, then high with all inputs 0 -> out_valid=0, out_data=0, in_ready=0; hold 5 cycles, no change.
- Fixed mode: mode=0, sel=2, en=1, ch2=8'hA5 valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=A5, out_ch=2, out_valid=1.
- Fixed-mode stall: out_ready=0 with ch2 still valid -> one load, then in_ready=0; out_data held at A5 for 4 cycles; out_ready=1 drains with 1/cycle throughput resuming.
- RR mode, all valid: mode=1, all 4 valid (data 11,22,33,44), out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
- RR mode, sparse: only ch1 and ch3 valid -> alternates 1,3,1. Drop ch3 -> ch1 is granted every cycle.
- en low / out-of-range / mid-transfer reset:
  - en=0 with valid inputs -> no accepts.
  - N_CH=3 build, sel=3 -> no grant.
  - rst_n pulse while out_valid=1 -> out_valid=0 and out_data=0 asynchronously.
  - With MUX_ARB_CNT_EN defined: out_count=0 after the pulse.
